sync_bcd_updown_cnt: RTL and testbench
======================================

// Module: sync_bcd_updown_cnt
// PURPOSE
//   Parametrised synchronous BCD up/down counter with a programmable modulus, parallel
//   load, count enable and a terminal-count flag. Every digit has its own 7-segment decoder.
//   It is the general counter/display stage for timers, clocks and event counters. It
//   replaces fixed 3-bit binary counters with a per-digit decoder. TC outputs cascade units.
// PARAMETERS
//   DIGITS   2    number of BCD digits (1..6)
//   MAX_VAL  59   terminal count, decimal; count modulus = MAX_VAL+1; must be < 10**DIGITS
// PORTS
//   CLK       in   1          clock; all state changes on falling edge of CLK
//   RESETN    in   1          synchronous reset, active-low
//   EN        in   1          count enable, 1 = step one count this edge
//   UP        in   1          direction: 1 = up, 0 = down
//   LOAD      in   1          parallel load strobe
//   LOAD_VAL  in   4*DIGITS   BCD load value, digit i at [4i+3:4i]
//   Q         out  4*DIGITS   registered BCD count, digit i at [4i+3:4i]
//   SEG       out  7*DIGITS   7-seg per digit, digit i at [7i+6:7i], bit order a..g MSB=a
//   TC        out  1          terminal count (combinational)
// BEHAVIOUR
//   - Single clock domain. RESETN is sampled on the falling edge of CLK. It is fully synchronous.
//   - Per edge priority is RESETN low, then LOAD, then EN, then hold.
//   - Reset: Q = 0. SEG = all 0 while RESETN is low; this is combinational blanking. TC = 0.
//   - LOAD=1: if every digit is <= 9 and the value is <= MAX_VAL, then Q <= LOAD_VAL.
//     Otherwise Q <= 0. LOAD overrides EN on the same edge.
//   - EN=1, UP=1: if Q == MAX_VAL, then Q <= 0. Otherwise Q does a BCD increment:
//     a digit at 9 rolls to 0 and carries into the next digit.
//   - EN=1, UP=0: if Q == 0, then Q <= MAX_VAL. Otherwise Q does a BCD decrement:
//     a digit at 0 becomes 9 and borrows from the next digit.
//   - EN=0 with LOAD=0: Q holds.
//   - Q never leaves 0..MAX_VAL and every digit stays in 0..9.
//   - Latency: Q changes one falling edge after inputs are sampled. SEG tracks Q combinationally.
//   - TC = RESETN & EN & ~LOAD & (UP ? Q==MAX_VAL : Q==0). TC is high during the cycle
//     whose closing edge wraps the counter. Drive the next unit's EN from TC.
//   - UP may change on any edge. The direction takes effect on that same edge. There is no
//     extra latency.
//   - Segment codes, active-high:
//       0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//       5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//     Any other digit code drives 0000000. These codes are unreachable.
//   - Arithmetic: the MAX_VAL comparison is against its BCD-encoded form. That form is a
//     localparam computed at elaboration.
// CONFIGURATION
//   LEAD_BLANK_EN defined: leading-zero blanking.
//     - Digit i > 0 drives SEG 0000000 when it and all higher digits are 0.
//     - Digit 0 is always displayed.
//     - Example: DIGITS=2, Q=07 -> upper digit blank, lower digit "7".
//   LEAD_BLANK_EN undefined: every digit is always decoded. Q=07 shows "0" and "7".
//   Q and TC are identical in both builds.
// TESTING
//   1. RESETN=0 for 2 edges, then RESETN=1, EN=1, UP=1 for 60 edges (DIGITS=2, MAX_VAL=59)
//      -> Q runs 00..59 then 00. TC is high only while Q=59.
//      Upper SEG is 1101101 at Q=20.
//   2. LOAD=1, LOAD_VAL=8'h09, then EN=1, UP=1 -> Q=09 then 10.
//      UP=0 at Q=10 -> Q=09 (borrow).
//   3. Q=00, EN=1, UP=0 -> Q=59, with TC high the cycle before.
//      LOAD_VAL=8'h75 or 8'h3A -> Q=00 (rejected).
//   4. LOAD=1 and EN=1 on the same edge, LOAD_VAL=8'h42 -> Q=42 (no step).
//      RESETN=0 mid-count at Q=33 -> Q=00 at that edge, SEG=0 while low.
//   5. Build with and without LEAD_BLANK_EN, load Q=05 -> upper SEG 0000000 vs 1111110.
//      Lower SEG is 1011011 in both builds.

Source files
------------

// File: rtl/sync_bcd_updown_cnt.sv
// sync_bcd_updown_cnt
//   Synchronous BCD up/down counter with a programmable terminal count.
//   It also has a parallel load, a count enable, a terminal-count flag and
//   one 7-segment decoder per digit.
//   All state changes on the falling edge of CLK. RESETN is sampled on that
//   same edge.
//   Optional build macro: LEAD_BLANK_EN. When it is defined, leading zeros
//   are blanked on the display. Q and TC are the same in both builds.
module sync_bcd_updown_cnt #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 59
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   Q,
  output logic [7*DIGITS-1:0]   SEG,
  output logic                  TC
);

  localparam int W = 4 * DIGITS;

  // Convert a decimal integer to packed BCD.
  // This is evaluated at elaboration to get the terminal count.
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  // True when every nibble holds a legal decimal digit.
  function automatic logic all_digits_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD increment: a 9 rolls to 0 and the carry ripples upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement: a 0 becomes 9 and the borrow ripples upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-high 7-segment code, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_max;
  logic         at_zero;
  logic         load_ok;

  assign at_max  = (q_q == MAX_BCD);
  assign at_zero = (q_q == '0);
  // When all digits are legal, BCD ordering matches unsigned ordering.
  // That lets the range check use a plain vector compare.
  assign load_ok = all_digits_valid(LOAD_VAL) && (LOAD_VAL <= MAX_BCD);

  // Next count. The priority is reset, then load, then step, then hold.
  always_comb begin
    q_d = q_q;
    if (!RESETN) begin
      q_d = '0;
    end else if (LOAD) begin
      q_d = load_ok ? LOAD_VAL : '0;
    end else if (EN) begin
      if (UP) begin
        q_d = at_max ? '0 : bcd_inc(q_q);
      end else begin
        q_d = at_zero ? MAX_BCD : bcd_dec(q_q);
      end
    end
  end

  // Count register, updated on the falling edge.
  always_ff @(negedge CLK) begin
    q_q <= q_d;
  end

  assign Q  = q_q;
  assign TC = RESETN & EN & ~LOAD & (UP ? at_max : at_zero);

  // One decoder per digit. The display is blanked while reset is held.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [6:0] seg_raw;
    logic       blank;

    assign seg_raw = seg_decode(q_q[4*g +: 4]);

`ifdef LEAD_BLANK_EN
    if (g == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = (q_q[W-1:4*g] == '0);
    end
`else
    assign blank = 1'b0;
`endif

    assign SEG[7*g +: 7] = (!RESETN || blank) ? 7'b0000000 : seg_raw;
  end

endmodule

// File: tb/tb_sync_bcd_updown_cnt.sv
// Directed testbench for sync_bcd_updown_cnt (DIGITS=2, MAX_VAL=59).
// Inputs are driven 1 ns after a falling edge and checked before the next one.
module tb_sync_bcd_updown_cnt;

  logic        CLK;
  logic        RESETN;
  logic        EN;
  logic        UP;
  logic        LOAD;
  logic [7:0]  LOAD_VAL;
  logic [7:0]  Q;
  logic [13:0] SEG;
  logic        TC;

  int checks;
  int errors;

  logic [6:0] segtab [10];

  sync_bcd_updown_cnt #(.DIGITS(2), .MAX_VAL(59)) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .EN       (EN),
    .UP       (UP),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .Q        (Q),
    .SEG      (SEG),
    .TC       (TC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [13:0] exp_seg(input int n);
    logic [6:0] hi;
    hi = segtab[n / 10];
`ifdef LEAD_BLANK_EN
    if (n / 10 == 0) hi = 7'b0000000;
`endif
    return {hi, segtab[n % 10]};
  endfunction

  task automatic test_reset();
    RESETN = 1'b0; EN = 1'b1; UP = 1'b0; LOAD = 1'b0; LOAD_VAL = 8'h00;
    step();
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
    checks++; if (SEG !== 14'h0) begin errors++; $display("FAIL reset_seg: got %b expected 0", SEG); end
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", TC); end
  endtask

  task automatic test_count_up();
    RESETN = 1'b1; EN = 1'b1; UP = 1'b1; LOAD = 1'b0;
    #1;
    for (int n = 0; n < 60; n++) begin
      checks++; if (Q !== bcd(n)) begin errors++; $display("FAIL up_q[%0d]: got %h expected %h", n, Q, bcd(n)); end
      checks++; if (TC !== (n == 59)) begin errors++; $display("FAIL up_tc[%0d]: got %b expected %b", n, TC, (n == 59)); end
      checks++; if (SEG !== exp_seg(n)) begin errors++; $display("FAIL up_seg[%0d]: got %b expected %b", n, SEG, exp_seg(n)); end
      if (n == 20) begin
        checks++; if (SEG[13:7] !== 7'b1101101) begin errors++; $display("FAIL up_seg_hi20: got %b expected 1101101", SEG[13:7]); end
      end
      step();
    end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL up_wrap: got %h expected 00", Q); end
  endtask

  task automatic test_load_carry();
    LOAD = 1'b1; EN = 1'b0; LOAD_VAL = 8'h09;
    step();
    checks++; if (Q !== 8'h09) begin errors++; $display("FAIL load09: got %h expected 09", Q); end
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    step();
    checks++; if (Q !== 8'h10) begin errors++; $display("FAIL carry10: got %h expected 10", Q); end
    UP = 1'b0;
    step();
    checks++; if (Q !== 8'h09) begin errors++; $display("FAIL borrow09: got %h expected 09", Q); end
    step();
    checks++; if (Q !== 8'h08) begin errors++; $display("FAIL dec08: got %h expected 08", Q); end
  endtask

  task automatic test_wrap_down();
    LOAD = 1'b1; EN = 1'b0; LOAD_VAL = 8'h00;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
    #1;
    checks++; if (TC !== 1'b1) begin errors++; $display("FAIL down_tc0: got %b expected 1", TC); end
    UP = 1'b1;
    #1;
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL up_tc_at0: got %b expected 0", TC); end
    UP = 1'b0;
    step();
    checks++; if (Q !== 8'h59) begin errors++; $display("FAIL down_wrap: got %h expected 59", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL down_tc59: got %b expected 0", TC); end
    EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 8'h75;
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reject75: got %h expected 00", Q); end
    LOAD_VAL = 8'h59;
    step();
    checks++; if (Q !== 8'h59) begin errors++; $display("FAIL accept59: got %h expected 59", Q); end
    LOAD_VAL = 8'h3A;
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reject3A: got %h expected 00", Q); end
    LOAD_VAL = 8'h30;
    step();
    LOAD_VAL = 8'h60;
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reject60: got %h expected 00", Q); end
    LOAD = 1'b0;
  endtask

  task automatic test_load_priority();
    LOAD = 1'b1; EN = 1'b0; LOAD_VAL = 8'h59;
    step();
    EN = 1'b1; UP = 1'b1; LOAD_VAL = 8'h42;
    #1;
    checks++; if (TC !== 1'b0) begin errors++; $display("FAIL tc_load_gate: got %b expected 0", TC); end
    step();
    checks++; if (Q !== 8'h42) begin errors++; $display("FAIL load_over_en: got %h expected 42", Q); end
    LOAD = 1'b0; EN = 1'b0;
    step();
    step();
    checks++; if (Q !== 8'h42) begin errors++; $display("FAIL hold: got %h expected 42", Q); end
  endtask

  task automatic test_reset_mid();
    LOAD = 1'b1; LOAD_VAL = 8'h33;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    RESETN = 1'b0;
    #1;
    checks++; if (SEG !== 14'h0) begin errors++; $display("FAIL mid_seg_blank: got %b expected 0", SEG); end
    checks++; if (Q !== 8'h33) begin errors++; $display("FAIL mid_q_before: got %h expected 33", Q); end
    step();
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL mid_reset_q: got %h expected 00", Q); end
    checks++; if (SEG !== 14'h0) begin errors++; $display("FAIL mid_seg_low: got %b expected 0", SEG); end
    RESETN = 1'b1; EN = 1'b0;
    #1;
  endtask

  task automatic test_blank();
    logic [6:0] exp_hi;
`ifdef LEAD_BLANK_EN
    exp_hi = 7'b0000000;
`else
    exp_hi = 7'b1111110;
`endif
    LOAD = 1'b1; LOAD_VAL = 8'h05;
    step();
    LOAD = 1'b0;
    checks++; if (SEG[13:7] !== exp_hi) begin errors++; $display("FAIL blank_hi: got %b expected %b", SEG[13:7], exp_hi); end
    checks++; if (SEG[6:0] !== 7'b1011011) begin errors++; $display("FAIL blank_lo: got %b expected 1011011", SEG[6:0]); end
  endtask

  initial begin
    segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
    segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
    segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1111011;
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_load_carry();
    test_wrap_down();
    test_load_priority();
    test_reset_mid();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
